// File: rtl/sfr_bus_pkg.sv
// -----------------------------------------------------------------------------
// sfr_bus_pkg
// Shared definitions for the SFR address/data bus: the address width that
// every sfr register instance decodes against, the default command/ack bytes
// of the UART framing, the default inter-byte timeout and the bus master FSM
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package sfr_bus_pkg;

    // Address width of the SFR bus; sfr register instances decode the same width.
    localparam int SFR_ADDR_W = 16;

    // Default framing bytes: 'W' opens a write, 'R' opens a read, 'K' acks a write.
    localparam logic [7:0] CMD_WR_DEF   = 8'h57;
    localparam logic [7:0] CMD_RD_DEF   = 8'h52;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h4B;

    // Default number of idle sys_clk cycles tolerated between bytes of one frame.
    localparam int TIMEOUT_CYC_DEF = 50000;

    // Bus master sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_H  = 3'd1,
        ST_ADDR_L  = 3'd2,
        ST_DATA    = 3'd3,
        ST_BUS_WR  = 3'd4,
        ST_BUS_RD  = 3'd5,
        ST_TX_RESP = 3'd6
    } sfr_state_e;

    // Operation latched from the command byte.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } sfr_op_e;

    // True while the FSM is waiting for the remaining bytes of a frame,
    // i.e. while the inter-byte timeout is meaningful.
    function automatic logic isFrameState(input sfr_state_e state);
        return (state == ST_ADDR_H) || (state == ST_ADDR_L) || (state == ST_DATA);
    endfunction

endpackage

// File: rtl/sfr_byte_timer.sv
// -----------------------------------------------------------------------------
// sfr_byte_timer
// Inter-byte timeout counter for the SFR bus master. Counts enabled cycles
// since the last restart and raises o_expire for one cycle once TIMEOUT_CYC
// cycles have elapsed without a restart.
// Ports:
//   i_clk      in  1  clock, rising edge
//   i_rst      in  1  synchronous reset, active-high
//   i_restart  in  1  clears the count (a new byte arrived)
//   i_enable   in  1  counting allowed; the count is held at zero otherwise
//   o_expire   out 1  one-cycle pulse on the TIMEOUT_CYC-th idle cycle
// -----------------------------------------------------------------------------
module sfr_byte_timer
#(
    parameter int TIMEOUT_CYC = 50000
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_expire;

    // The count only reaches CNT_LAST after TIMEOUT_CYC consecutive enabled
    // cycles with no restart; a restart in the same cycle always wins so a
    // byte arriving exactly at the deadline still keeps the frame alive.
    assign w_expire = i_enable && !i_restart && (r_count == CNT_LAST);
    assign o_expire = w_expire;

    // The counter is cleared whenever counting is not wanted, on restart and
    // after it fires, so every new frame and every new byte starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart || !i_enable || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sfr_bus_master.sv
// -----------------------------------------------------------------------------
// sfr_bus_master
// Initiator side of the SFR address/data bus. Turns a UART byte stream into
// SFR register cycles:
//   'W' addr_hi addr_lo data -> one bus write cycle
//   'R' addr_hi addr_lo      -> one bus read cycle, read byte sent back on TX
// Configuration macro: SFR_WT_ACK_EN - when defined, every completed write is
// answered with ACK_BYTE on the TX stream; when undefined writes are silent.
// Ports:
//   sys_clk      in    1   system clock, rising edge
//   sys_rst      in    1   synchronous reset, active-high
//   i_rx_data    in    8   received UART byte
//   i_rx_valid   in    1   one-cycle strobe, i_rx_data valid
//   o_tx_data    out   8   byte to transmit
//   o_tx_valid   out   1   o_tx_data valid, held until accepted
//   i_tx_ready   in    1   TX engine takes the byte when valid && ready
//   o_address    out   16  SFR bus address
//   o_ad_set     out   1   bus write strobe, one cycle
//   o_ad_enable  out   1   bus read enable, one cycle
//   io_ad_data   inout 8   shared SFR data bus, driven only during o_ad_set
//   o_busy       out   1   high whenever not idle
//   o_err        out   1   one-cycle pulse: bad command, overrun or timeout
// -----------------------------------------------------------------------------
module sfr_bus_master
    import sfr_bus_pkg::*;
#(
    parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
`ifdef SFR_WT_ACK_EN
    parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
`endif
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [SFR_ADDR_W-1:0] o_address,
    output logic                  o_ad_set,
    output logic                  o_ad_enable,
    inout  wire  [7:0]            io_ad_data,
    output logic                  o_busy,
    output logic                  o_err
);

    sfr_state_e            r_state;
    sfr_state_e            w_stateNext;
    sfr_op_e               r_op;
    logic [7:0]            r_addrHi;
    logic [7:0]            r_addrLo;
    logic [7:0]            r_data;
    logic [7:0]            r_txData;
    logic [SFR_ADDR_W-1:0] r_address;
    logic                  r_err;
    logic                  w_errNext;
    logic                  w_isCmd;
    logic                  w_timeout;

    assign w_isCmd = (i_rx_data == CMD_WR) || (i_rx_data == CMD_RD);

    // The inter-byte watchdog only runs while a frame is partially received;
    // every accepted byte restarts it.
    sfr_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_restart (i_rx_valid),
        .i_enable  (isFrameState(r_state)),
        .o_expire  (w_timeout)
    );

    // State register. Reset drops any frame or pending response on the spot.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and error decode. Bytes that arrive while the bus cycle or
    // the response is in flight cannot be buffered, so they are dropped and
    // flagged without disturbing the sequence in progress.
    always_comb begin
        w_stateNext = r_state;
        w_errNext   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (w_isCmd) begin
                        w_stateNext = ST_ADDR_H;
                    end else begin
                        w_errNext = 1'b1;
                    end
                end
            end
            ST_ADDR_H: begin
                if (i_rx_valid) begin
                    w_stateNext = ST_ADDR_L;
                end else if (w_timeout) begin
                    w_stateNext = ST_IDLE;
                    w_errNext   = 1'b1;
                end
            end
            ST_ADDR_L: begin
                if (i_rx_valid) begin
                    w_stateNext = (r_op == OP_READ) ? ST_BUS_RD : ST_DATA;
                end else if (w_timeout) begin
                    w_stateNext = ST_IDLE;
                    w_errNext   = 1'b1;
                end
            end
            ST_DATA: begin
                if (i_rx_valid) begin
                    w_stateNext = ST_BUS_WR;
                end else if (w_timeout) begin
                    w_stateNext = ST_IDLE;
                    w_errNext   = 1'b1;
                end
            end
            ST_BUS_WR: begin
`ifdef SFR_WT_ACK_EN
                w_stateNext = ST_TX_RESP;
`else
                w_stateNext = ST_IDLE;
`endif
                w_errNext = i_rx_valid;
            end
            ST_BUS_RD: begin
                w_stateNext = ST_TX_RESP;
                w_errNext   = i_rx_valid;
            end
            ST_TX_RESP: begin
                if (i_tx_ready) begin
                    w_stateNext = ST_IDLE;
                end
                w_errNext = i_rx_valid;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Frame datapath. The bus address is loaded on the same edge that enters
    // the bus cycle, so it changes only as the strobe rises and otherwise
    // keeps showing the last address used. A read takes its low address byte
    // straight from the RX port because that byte is the last of the frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_op      <= OP_WRITE;
            r_addrHi  <= '0;
            r_addrLo  <= '0;
            r_data    <= '0;
            r_txData  <= '0;
            r_address <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_errNext;
            if ((r_state == ST_IDLE) && i_rx_valid && w_isCmd) begin
                r_op <= (i_rx_data == CMD_RD) ? OP_READ : OP_WRITE;
            end
            if ((r_state == ST_ADDR_H) && i_rx_valid) begin
                r_addrHi <= i_rx_data;
            end
            if ((r_state == ST_ADDR_L) && i_rx_valid) begin
                r_addrLo <= i_rx_data;
                if (r_op == OP_READ) begin
                    r_address <= {r_addrHi, i_rx_data};
                end
            end
            if ((r_state == ST_DATA) && i_rx_valid) begin
                r_data    <= i_rx_data;
                r_address <= {r_addrHi, r_addrLo};
            end
            if (r_state == ST_BUS_RD) begin
                r_txData <= io_ad_data;
            end
`ifdef SFR_WT_ACK_EN
            if (r_state == ST_BUS_WR) begin
                r_txData <= ACK_BYTE;
            end
`endif
        end
    end

    // Bus strobes are decoded from distinct states, so set and enable can
    // never overlap; the data bus is only driven during the write strobe.
    assign o_ad_set    = (r_state == ST_BUS_WR);
    assign o_ad_enable = (r_state == ST_BUS_RD);
    assign io_ad_data  = o_ad_set ? r_data : 8'hzz;
    assign o_address   = r_address;
    assign o_tx_valid  = (r_state == ST_TX_RESP);
    assign o_tx_data   = r_txData;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule

// File: tb/tb_sfr_bus_master.sv
// -----------------------------------------------------------------------------
// tb_sfr_bus_master
// Directed self-checking bench for sfr_bus_master. A small register-file
// target sits on the shared data bus; bytes are fed one at a time on the RX
// strobe and outputs are sampled on the falling clock edge.
// Honours SFR_WT_ACK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_sfr_bus_master;

    localparam int TO_CYC = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [15:0] o_address;
    logic        o_ad_set;
    logic        o_ad_enable;
    wire  [7:0]  adBus;
    logic        o_busy;
    logic        o_err;

    logic [7:0]  tgtMem [0:255];
    int          checkCount = 0;
    int          errorCount = 0;
    int          setPulses  = 0;
    int          setBefore;

    sfr_bus_master #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_address   (o_address),
        .o_ad_set    (o_ad_set),
        .o_ad_enable (o_ad_enable),
        .io_ad_data  (adBus),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Register-file target: answers reads while enabled, captures writes on
    // the strobe edge. Addresses alias on the low byte.
    assign adBus = o_ad_enable ? tgtMem[o_address[7:0]] : 8'hzz;

    always @(posedge sys_clk) begin
        if (o_ad_set) begin
            tgtMem[o_address[7:0]] <= adBus;
            setPulses <= setPulses + 1;
        end
    end

    // Compares one observed value with its expected value and logs a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one byte with a single-cycle RX strobe; returns on the falling
    // edge right after the byte was sampled.
    task automatic applyStimulus(input logic [7:0] rxByte);
        @(negedge sys_clk);
        i_rx_data  = rxByte;
        i_rx_valid = 1'b1;
        @(negedge sys_clk);
        i_rx_valid = 1'b0;
    endtask

    // Follows the cycle after a write strobe: an ack byte when enabled,
    // otherwise straight back to idle.
    task automatic finishWrite(input string tag);
        @(negedge sys_clk);
`ifdef SFR_WT_ACK_EN
        checkOutput({tag, "_ackValid"}, 32'(o_tx_valid), 32'd1);
        checkOutput({tag, "_ackData"}, 32'(o_tx_data), 32'h4B);
        i_tx_ready = 1'b1;
        @(negedge sys_clk);
        i_tx_ready = 1'b0;
        checkOutput({tag, "_ackDone"}, 32'(o_tx_valid), 32'd0);
`else
        checkOutput({tag, "_noTx"}, 32'(o_tx_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(o_busy), 32'd0);
`endif
    endtask

    // Strobes must never overlap whenever either is active.
    always @(negedge sys_clk) begin
        if (o_ad_set || o_ad_enable) begin
            checkOutput("strobeExclusive", 32'(o_ad_set && o_ad_enable), 32'd0);
        end
    end

    initial begin
        sys_rst    = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Reset values.
        checkOutput("rst_address", 32'(o_address), 32'h0);
        checkOutput("rst_adSet", 32'(o_ad_set), 32'd0);
        checkOutput("rst_adEnable", 32'(o_ad_enable), 32'd0);
        checkOutput("rst_txValid", 32'(o_tx_valid), 32'd0);
        checkOutput("rst_txData", 32'(o_tx_data), 32'h0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        sys_rst = 1'b0;

        // Write 1234 = A5.
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkOutput("wr_busyInDATA", 32'(o_busy), 32'd1);
        checkOutput("wr_noSetEarly", 32'(o_ad_set), 32'd0);
        applyStimulus(8'hA5);
        checkOutput("wr_adSet", 32'(o_ad_set), 32'd1);
        checkOutput("wr_address", 32'(o_address), 32'h1234);
        checkOutput("wr_bus", 32'(adBus), 32'hA5);
        checkOutput("wr_noEnable", 32'(o_ad_enable), 32'd0);
        finishWrite("wr1");
        checkOutput("wr_setOneCycle", 32'(o_ad_set), 32'd0);
        checkOutput("wr_targetA5", 32'(tgtMem[8'h34]), 32'hA5);
        checkOutput("wr_setCount", 32'(setPulses), 32'd1);

        // Overwrite 1234 = 3C, then read it back with a stalled TX engine.
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h3C);
        finishWrite("wr2");
        applyStimulus(8'h52);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        checkOutput("rd_adEnable", 32'(o_ad_enable), 32'd1);
        checkOutput("rd_address", 32'(o_address), 32'h1234);
        checkOutput("rd_noSet", 32'(o_ad_set), 32'd0);
        checkOutput("rd_txNotYet", 32'(o_tx_valid), 32'd0);
        @(negedge sys_clk);
        checkOutput("rd_txValid", 32'(o_tx_valid), 32'd1);
        checkOutput("rd_txData", 32'(o_tx_data), 32'h3C);
        checkOutput("rd_enableOneCycle", 32'(o_ad_enable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            checkOutput("rd_holdValid", 32'(o_tx_valid), 32'd1);
            checkOutput("rd_holdData", 32'(o_tx_data), 32'h3C);
        end

        // Overrun while the response waits.
        applyStimulus(8'h99);
        checkOutput("ovr_err", 32'(o_err), 32'd1);
        checkOutput("ovr_txValid", 32'(o_tx_valid), 32'd1);
        checkOutput("ovr_txData", 32'(o_tx_data), 32'h3C);
        @(negedge sys_clk);
        checkOutput("ovr_errPulse", 32'(o_err), 32'd0);
        i_tx_ready = 1'b1;
        @(negedge sys_clk);
        i_tx_ready = 1'b0;
        checkOutput("rd_accepted", 32'(o_tx_valid), 32'd0);
        checkOutput("rd_idle", 32'(o_busy), 32'd0);

        // Bad command byte.
        setBefore = setPulses;
        applyStimulus(8'h41);
        checkOutput("bad_err", 32'(o_err), 32'd1);
        checkOutput("bad_busy", 32'(o_busy), 32'd0);
        checkOutput("bad_noEnable", 32'(o_ad_enable), 32'd0);
        @(negedge sys_clk);
        checkOutput("bad_errPulse", 32'(o_err), 32'd0);
        checkOutput("bad_noSet", 32'(setPulses), 32'(setBefore));

        // Inter-byte timeout after 'W' 12.
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        repeat (TO_CYC - 1) @(negedge sys_clk);
        checkOutput("to_stillBusy", 32'(o_busy), 32'd1);
        checkOutput("to_noErrYet", 32'(o_err), 32'd0);
        @(negedge sys_clk);
        checkOutput("to_err", 32'(o_err), 32'd1);
        checkOutput("to_idle", 32'(o_busy), 32'd0);
        @(negedge sys_clk);
        checkOutput("to_errPulse", 32'(o_err), 32'd0);
        checkOutput("to_noSet", 32'(setPulses), 32'(setBefore));

        // Normal traffic afterwards: write 0000 = 5A, read it back.
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h5A);
        checkOutput("wr0_address", 32'(o_address), 32'h0000);
        finishWrite("wr0");
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("rd0_adEnable", 32'(o_ad_enable), 32'd1);
        @(negedge sys_clk);
        checkOutput("rd0_txData", 32'(o_tx_data), 32'h5A);
        i_tx_ready = 1'b1;
        @(negedge sys_clk);
        i_tx_ready = 1'b0;
        checkOutput("rd0_idle", 32'(o_busy), 32'd0);

        // Reset while waiting for the data byte of a write.
        applyStimulus(8'h57);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        setBefore = setPulses;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checkOutput("mrst_busy", 32'(o_busy), 32'd0);
        checkOutput("mrst_address", 32'(o_address), 32'h0);
        checkOutput("mrst_txData", 32'(o_tx_data), 32'h0);
        checkOutput("mrst_txValid", 32'(o_tx_valid), 32'd0);
        applyStimulus(8'hA5);
        checkOutput("mrst_dataAsCmdErr", 32'(o_err), 32'd1);
        repeat (3) @(negedge sys_clk);
        checkOutput("mrst_noSet", 32'(setPulses), 32'(setBefore));
        checkOutput("mrst_idle", 32'(o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
